// File: rtl/uart_tx_arbiter.sv
// Two-source round-robin arbiter feeding one 8N1 UART transmitter.
// IDLE picks a requester, then START/DATA/STOP shift the latched byte out LSB first.
module uart_tx_arbiter #(
  parameter int CLK_DIV = 104,
  parameter int DATA_W  = 8
) (
  input  logic              io_mainClk,
  input  logic              io_asyncResetN,
  input  logic              io_req0_valid,
  input  logic [DATA_W-1:0] io_req0_data,
  output logic              io_req0_ready,
  input  logic              io_req1_valid,
  input  logic [DATA_W-1:0] io_req1_data,
  output logic              io_req1_ready,
  output logic              io_txd,
  output logic              io_busy,
  output logic              io_grant
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q;
  logic [15:0]       baud_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              txd_q;
  logic              busy_q;
  logic              grant_q;
  logic              last_q;
  logic              sel;
  logic              accept;
  logic              baud_end;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    sel = 1'b0;
    if (io_req0_valid && io_req1_valid) sel = ~last_q;
    else if (io_req1_valid)             sel = 1'b1;
  end

  assign io_req0_ready = io_asyncResetN && (state_q == IDLE) && io_req0_valid && !sel;
  assign io_req1_ready = io_asyncResetN && (state_q == IDLE) && io_req1_valid &&  sel;
  assign accept        = io_req0_ready || io_req1_ready;
  assign baud_end      = (baud_q == 16'(CLK_DIV - 1));

  always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
    if (!io_asyncResetN) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= sel ? io_req1_data : io_req0_data;
            grant_q <= sel;
            last_q  <= sel;
            state_q <= START;
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            txd_q   <= shift_q[0];
            shift_q <= shift_q >> 1;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == BIT_W'(DATA_W - 1)) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              txd_q   <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_q  <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_txd   = txd_q;
  assign io_busy  = busy_q;
  assign io_grant = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues expected frames, a serial monitor decodes io_txd.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic       use2 = 1'b0;

  logic r0_4, r1_4, txd4, busy4, g4;
  logic r0_2, r1_2, txd2, busy2, g2;
  logic m_r0, m_r1, m_txd, m_busy, m_grant;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.CLK_DIV(4), .DATA_W(8)) dut4 (
    .io_mainClk(clk), .io_asyncResetN(rst_n),
    .io_req0_valid(v0), .io_req0_data(d0), .io_req0_ready(r0_4),
    .io_req1_valid(v1), .io_req1_data(d1), .io_req1_ready(r1_4),
    .io_txd(txd4), .io_busy(busy4), .io_grant(g4));

  uart_tx_arbiter #(.CLK_DIV(2), .DATA_W(8)) dut2 (
    .io_mainClk(clk), .io_asyncResetN(rst_n),
    .io_req0_valid(v0), .io_req0_data(d0), .io_req0_ready(r0_2),
    .io_req1_valid(v1), .io_req1_data(d1), .io_req1_ready(r1_2),
    .io_txd(txd2), .io_busy(busy2), .io_grant(g2));

  assign m_r0    = use2 ? r0_2  : r0_4;
  assign m_r1    = use2 ? r1_2  : r1_4;
  assign m_txd   = use2 ? txd2  : txd4;
  assign m_busy  = use2 ? busy2 : busy4;
  assign m_grant = use2 ? g2    : g4;

  typedef struct packed {logic g; logic [7:0] d;} exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   st_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   both_seen = 1'b0;
  bit   rdy_busy_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic g, input logic [7:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Accept detection and ready-rule watch on the monitored instance.
  always @(negedge clk) begin
    if (m_r0 && m_r1) both_seen = 1'b1;
    if ((m_r0 || m_r1) && m_busy) rdy_busy_seen = 1'b1;
    if ((m_r0 && v0) || (m_r1 && v1)) acc_q.push_back(cyc);
  end

  task automatic rx_frame(output bit ab, output logic [7:0] got, output bit shape_ok, output bit bsy_ok);
    int cd = use2 ? 2 : 4;
    ab = 1'b0; got = '0; shape_ok = 1'b1; bsy_ok = (m_busy === 1'b1);
    for (int c = 1; c < cd; c++) begin
      @(negedge clk);
      if (!rst_n) begin ab = 1'b1; return; end
      if (m_txd !== 1'b0) shape_ok = 1'b0;
      if (m_busy !== 1'b1) bsy_ok = 1'b0;
    end
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c < cd; c++) begin
        @(negedge clk);
        if (!rst_n) begin ab = 1'b1; return; end
        if (c == 0) got[b] = m_txd;
        else if (m_txd !== got[b]) shape_ok = 1'b0;
        if (m_busy !== 1'b1) bsy_ok = 1'b0;
      end
    end
    for (int c = 0; c < cd; c++) begin
      @(negedge clk);
      if (!rst_n) begin ab = 1'b1; return; end
      if (m_txd !== 1'b1) shape_ok = 1'b0;
      if (m_busy !== 1'b1) bsy_ok = 1'b0;
    end
  endtask

  initial begin : mon
    bit         ab, sok, bok, gap;
    logic [7:0] got;
    logic       g;
    int         st;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst_n && m_txd === 1'b0) begin
        st = cyc;
        g  = m_grant;
        rx_frame(ab, got, sok, bok);
        if (ab) begin
          exp_q.delete();
        end else begin
          @(negedge clk);
          gap = (m_txd === 1'b1) && (m_busy === 1'b0);
          st_q.push_back(st);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_frame: got %02h, none expected", got);
          end else begin
            e = exp_q.pop_front();
            chk("frame_data", got, e.d);
            chk("frame_grant", g, e.g);
            chk("frame_shape", sok, 1);
            chk("busy_in_frame", bok, 1);
            chk("idle_after_stop", gap, 1);
          end
        end
      end
    end
  end

  task automatic wait_acc(input int n);
    int t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (acc_q.size() < n && t < 3000);
    #1;
    chk("accept_reached", acc_q.size() >= n, 1);
  endtask

  task automatic wait_done();
    int t = 0;
    do begin
      @(posedge clk);
      t++;
    end while ((exp_q.size() != 0 || m_busy) && t < 5000);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic clear_logs();
    acc_q.delete();
    st_q.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Test 2 first: both requesters valid straight out of reset.
    v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", txd4, 1);
    chk("rst_busy", busy4, 0);
    chk("rst_grant", g4, 0);
    chk("rst_ready0", r0_4, 0);
    chk("rst_ready1", r1_4, 0);
    chk("rst_txd_div2", txd2, 1);
    push_exp(1'b0, 8'h11); push_exp(1'b1, 8'h22);
    push_exp(1'b0, 8'h11); push_exp(1'b1, 8'h22);
    rst_n = 1'b1;
    wait_acc(4);
    v0 = 1'b0; v1 = 1'b0;
    wait_done();
    for (int i = 0; i < 3; i++) chk("tie_spacing", acc_q[i+1] - acc_q[i], 41);
    chk("both_ready", both_seen, 0);

    // Test 1: single byte from req0.
    clear_logs();
    push_exp(1'b0, 8'hA5);
    d0 = 8'hA5; v0 = 1'b1;
    wait_acc(1);
    v0 = 1'b0;
    wait_done();
    chk("start_latency", st_q[0] - acc_q[0], 1);

    // Test 3: req1 alone, three back-to-back bytes.
    clear_logs();
    push_exp(1'b1, 8'h00); push_exp(1'b1, 8'hFF); push_exp(1'b1, 8'h5A);
    d1 = 8'h00; v1 = 1'b1;
    wait_acc(1); d1 = 8'hFF;
    wait_acc(2); d1 = 8'h5A;
    wait_acc(3); v1 = 1'b0;
    wait_done();
    for (int i = 0; i < 2; i++) chk("b2b_spacing", acc_q[i+1] - acc_q[i], 41);
    for (int i = 0; i < 2; i++) chk("b2b_start_spacing", st_q[i+1] - st_q[i], 41);

    // Test 4: reset during data bit 3 of 0x0F.
    clear_logs();
    push_exp(1'b0, 8'h0F);
    d0 = 8'h0F; v0 = 1'b1;
    wait_acc(1);
    v0 = 1'b0;
    repeat (17) @(posedge clk);
    #2;
    chk("pre_reset_busy", busy4, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_txd", txd4, 1);
    chk("async_rst_busy", busy4, 0);
    chk("async_rst_grant", g4, 0);
    v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
    #1;
    chk("rst_ready0_held", r0_4, 0);
    chk("rst_ready1_held", r1_4, 0);
    @(negedge clk); @(negedge clk);
    @(posedge clk);
    #1;
    clear_logs();
    push_exp(1'b0, 8'h11); push_exp(1'b1, 8'h22);
    rst_n = 1'b1;
    wait_acc(2);
    v0 = 1'b0; v1 = 1'b0;
    wait_done();

    // Test 5: data changes mid-frame are ignored.
    clear_logs();
    push_exp(1'b0, 8'h33); push_exp(1'b0, 8'h44);
    d0 = 8'h33; v0 = 1'b1;
    wait_acc(1);
    repeat (2) @(posedge clk);
    #1;
    d0 = 8'h44;
    wait_acc(2);
    v0 = 1'b0;
    wait_done();
    chk("hold_spacing", acc_q[1] - acc_q[0], 41);
    chk("ready_while_busy", rdy_busy_seen, 0);

    // Test 6: CLK_DIV = 2 instance.
    use2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    push_exp(1'b0, 8'h80);
    d0 = 8'h80; v0 = 1'b1;
    wait_acc(1);
    v0 = 1'b0;
    wait_done();
    chk("start_latency_div2", st_q[0] - acc_q[0], 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single board UART transmit pin between two byte-stream requesters: requester 0 is the Murax UART, requester 1 is a hardware status/debug source.
- Serializes 8N1 frames with an internal baud counter.
- Grants round-robin on ties, so neither source can starve the other.
- Sits between the SoC and the UART_TX pad in the board toplevel.

Parameters:
- CLK_DIV, 104, io_mainClk cycles per bit (12 MHz / 115200). Legal range 2..65535.
- DATA_W, 8, data bits per frame. Fixed at 8 for this board; the parameter exists only for the bench.

Ports:
- io_mainClk  input  1  system clock.
- io_asyncResetN  input  1  asynchronous active-low reset.
- io_req0_valid  input  1  requester 0 has a byte.
- io_req0_data  input  DATA_W  requester 0 byte.
- io_req0_ready  output  1  requester 0 byte accepted this cycle when valid&ready.
- io_req1_valid  input  1  requester 1 has a byte.
- io_req1_data  input  DATA_W  requester 1 byte.
- io_req1_ready  output  1  requester 1 byte accepted this cycle when valid&ready.
- io_txd  output  1  serial output to the UART_TX pad; idle high.
- io_busy  output  1  frame in progress.
- io_grant  output  1  index of the requester owning the current or most recent frame.

Behaviour:
- Clock and reset:
  - One clock, io_mainClk.
  - Reset is asynchronous, active-low, on io_asyncResetN.
- Reset values:
  - io_txd=1, io_busy=0, io_grant=0.
  - Internal last-winner pointer = 1, so requester 0 wins the first tie.
  - State IDLE; baud counter and bit index = 0.
  - Both ready outputs are forced 0 while reset is asserted.
- States: IDLE, START, DATA, STOP.
- Arbitration (combinational, IDLE only):
  - sel = the single valid requester.
  - If both are valid, sel = the requester that is not the last winner.
  - io_reqK_ready = (state==IDLE) && io_reqK_valid && (sel==K).
  - At most one ready is high in any cycle. Both are 0 outside IDLE.
- Accept (rising edge where valid&ready):
  - Latch that requester's data into the shift register.
  - io_grant <= sel; last winner <= sel.
  - state <= START; baud counter <= 0.
- START:
  - io_txd=0 for exactly CLK_DIV cycles, beginning the cycle after accept.
  - Then DATA, with bit index 0.
- DATA:
  - io_txd = shift register bit, LSB first. Each bit is held CLK_DIV cycles.
  - After bit DATA_W-1 completes, go to STOP.
- STOP:
  - io_txd=1 for CLK_DIV cycles, then IDLE.
- Baud counter:
  - Counts 0..CLK_DIV-1 and wraps to 0 on each bit boundary.
  - Never exceeds CLK_DIV-1.
- Frame timing:
  - A frame occupies (DATA_W+2)*CLK_DIV cycles.
  - The minimum back-to-back period is (DATA_W+2)*CLK_DIV+1 cycles, because one IDLE cycle (txd high) is needed to accept.
- io_busy: 1 in START/DATA/STOP, 0 in IDLE.
- io_txd is registered; no combinational path from inputs to io_txd.
- Input stability:
  - Requester data need only be stable in the accept cycle.
  - Changes to valid or data mid-frame have no effect.
- Reset mid-frame:
  - io_txd returns high immediately (asynchronously) and state goes to IDLE.
  - The partial frame is abandoned, with no completion or retry.
  - io_grant and the last-winner pointer return to their reset values.
- Simultaneous valid on both requesters while busy: both wait. The winner is decided in the next IDLE cycle by round-robin.
- Valid dropped by a requester before it is granted is legal; no byte is consumed.

Test Plan:
1. CLK_DIV=4, reset released, req0 sends 0xA5 alone.
   - Accept at cycle T; io_txd low T+1..T+4.
   - Bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles.
   - io_busy high 40 cycles; io_grant=0.
2. CLK_DIV=4, both valid from reset with req0=0x11, req1=0x22, held high.
   - Frames go out in order 0x11 (grant 0), 0x22 (grant 1), 0x11, 0x22.
   - Accept cycles are exactly 41 cycles apart.
   - Never are both ready high in the same cycle.
3. CLK_DIV=4, req1 alone sends 3 back-to-back bytes 0x00, 0xFF, 0x5A.
   - All three are granted to req1 with no starvation stall.
   - Exactly one txd-high IDLE cycle between stop bit and next start bit.
4. CLK_DIV=4, io_asyncResetN pulsed low during DATA bit 3 of 0x0F from req0.
   - io_txd=1 and io_busy=0 within the reset cycle without a clock edge.
   - After release, with both valid, req0 is granted first.
5. CLK_DIV=4, req0 asserts valid with 0x33, then changes data to 0x44 two cycles after accept.
   - Transmitted frame is 0x33; ready stays 0 until frame end.
6. CLK_DIV=2 minimum, send 0x80.
   - Start bit 2 cycles; seven 0 bits then a 1 bit; stop bit 2 cycles.
   - Total busy 20 cycles.
